perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- In-hardware performance counter bank for the NPC core.
- Samples the same IFU, ICache and LSU event signals that feed the simulator-side DPI probe, and accumulates them in 64-bit counters.
- Software reads the counters over a simple request/response MMIO port. This block is the reader/consumer end of that event interface.
- Sits beside the core, with its bus port hung off the peripheral crossbar.

Parameters:
- CNT_WIDTH, 64: counter width. Legal range 33..64. Bits above CNT_WIDTH read as 0.
- NUM_CNT, 8: number of counters. Fixed at 8; the address map depends on it.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (reset==0 asserts)
- ifu_valid  in  1  one-cycle pulse per instruction fetched
- icache_valid  in  1  one-cycle pulse: icache lookup completes
- icache_start  in  1  level: icache memory fetch in progress
- icache_isHit  in  1  hit flag; qualified by icache_valid
- lsu_ren  in  1  LSU read request
- lsu_wen  in  1  LSU write request
- lsu_isWaiting  in  1  level: LSU waiting on memory
- req_valid  in  1  bus request valid
- req_ready  out  1  bus request ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  8  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_rdata  out  32  read data
- resp_err  out  1  access error

Behaviour:
- Reset values: all counters 0, ctrl 0, shadow 0, edge registers 0, FSM IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Counter events; each counter increments by at most 1 per cycle, and only while ctrl.freeze==0:
  - C0 cycle: every cycle.
  - C1 inst: ifu_valid.
  - C2 icache_fetch: rising edge of icache_start.
  - C3 icache_hit: icache_valid & icache_isHit.
  - C4 icache_miss: icache_valid & ~icache_isHit.
  - C5 lsu_load: rising edge of lsu_isWaiting & lsu_ren.
  - C6 lsu_store: rising edge of lsu_isWaiting & lsu_wen.
  - C7 lsu_wait: lsu_isWaiting.
- Rising edge: signal==1 and the previous-cycle register==0. Edge registers reset to 0, so a level already high at reset release counts once.
- Arithmetic: counters wrap modulo 2^CNT_WIDTH with no saturation and no overflow flag.
- Address map:
  - Counter i low word at 8*i; high word at 8*i+4.
  - CTRL at 0x40: bit0 freeze (R/W); bit1 clear (write-1, self-clearing, reads 0).
  - All other addresses: resp_err=1, rdata=0.
- Snapshot:
  - A read of a low word returns counter[31:0] and latches counter[CNT_WIDTH-1:32] into a single shadow register.
  - A read of any high word returns the shadow, not the live value.
  - Software must read low then high.
- Read value: the registered counter value at the accept cycle, i.e. pre-increment if an event fires that cycle.
- Writes to counter addresses: ignored, resp_err=1.
- Clear: writing CTRL bit1=1 zeroes all counters and the shadow on the cycle after accept.
  - Clear has priority over a same-cycle increment.
  - Freeze takes the written bit0 in the same write.
- Bus FSM:
  - IDLE: req_ready=1. On req_valid, accept, compute the response, go to RESP.
  - RESP: req_ready=0, resp_valid=1. Hold rdata/err stable until resp_ready. On resp_ready go to IDLE.
  - Latency: response valid exactly 1 cycle after accept. One outstanding request; throughput 1 per 2 cycles minimum.
- Asynchronous reset mid-transaction: FSM returns to IDLE immediately, resp_valid drops, and the pending response is discarded.

Decomposition:
- Package perf_pkg: event index constants (EV_CYCLE..EV_LSU_WAIT), NUM_CNT, CTRL_ADDR=0x40, CTRL bit positions, bus FSM state enum.
- Sub-module perf_event_counter: one CNT_WIDTH counter with inc, clear and freeze inputs and wrap arithmetic. Instantiated 8 times.
- Edge detect and address decode stay in the top level.

Test Plan:
- Reset, run 100 cycles idle, read C0 lo/hi -> lo≈100 plus the bus cycles spent (exact value checked against the model), hi=0. All other counters 0.
- 5 ifu_valid pulses, 3 icache_valid with hit=1, 2 with hit=0 -> C1=5, C3=3, C4=2.
- lsu_isWaiting high for 4 cycles with ren=1, then high 2 cycles with wen=1 (low gap between) -> C5=1, C6=1, C7=6.
- Wrap case: preload C0 near 2^64-1 (force), then read lo -> wrapped value; read hi -> shadow from the lo read even though the live counter has since advanced.
- Write CTRL=0x1 (freeze) during events -> counters unchanged. Then write 0x2 -> all counters 0 and CTRL reads 0x0. Write to 0x04 -> resp_err=1.
- Hold resp_ready=0 for 3 cycles -> resp_valid and rdata stable, req_ready=0. Assert reset mid-RESP -> resp_valid=0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: event slots, CTRL layout
// and the bus-side state encoding.
package perf_pkg;

    localparam int NUM_CNT = 8;

    localparam int EV_CYCLE        = 0;
    localparam int EV_INST         = 1;
    localparam int EV_ICACHE_FETCH = 2;
    localparam int EV_ICACHE_HIT   = 3;
    localparam int EV_ICACHE_MISS  = 4;
    localparam int EV_LSU_LOAD     = 5;
    localparam int EV_LSU_STORE    = 6;
    localparam int EV_LSU_WAIT     = 7;

    localparam logic [7:0] CTRL_ADDR  = 8'h40;
    localparam int CTRL_FREEZE_BIT    = 0;
    localparam int CTRL_CLEAR_BIT     = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/perf_event_counter.sv
// Single wrapping event counter; clear wins over increment, freeze blocks increment.
module perf_event_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    input  logic                 i_clear,
    input  logic                 i_freeze,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;

    // next-count selection
    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = {CNT_WIDTH{1'b0}};
        end else if (i_inc && !i_freeze) begin
            w_count_nxt = r_count + CNT_WIDTH'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // count register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/perf_counter_bank.sv
// Eight hardware performance counters fed by IFU/ICache/LSU events and read
// over a single-outstanding request/response MMIO port with a low-then-high snapshot.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_valid,
    input  logic        icache_valid,
    input  logic        icache_start,
    input  logic        icache_isHit,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic        lsu_isWaiting,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    logic                 r_icache_start_d;
    logic                 r_lsu_load_d;
    logic                 r_lsu_store_d;
    logic                 r_freeze;
    logic [31:0]          r_shadow;
    bus_state_e           r_state;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_resp_err;

    logic                 w_lsu_load_lvl;
    logic                 w_lsu_store_lvl;
    logic [NUM_CNT-1:0]   w_event;
    logic [CNT_WIDTH-1:0] w_count [NUM_CNT];
    logic                 w_accept;
    logic                 w_is_cnt;
    logic                 w_is_ctrl;
    logic [2:0]           w_idx;
    logic [CNT_WIDTH-1:0] w_sel;
    logic [31:0]          w_sel_hi;
    logic [31:0]          w_rdata;
    logic                 w_err;
    logic                 w_shadow_load;
    logic                 w_clear;
    logic                 w_freeze_nxt;
    bus_state_e           w_state_nxt;
    logic                 w_req_ready_nxt;
    logic                 w_resp_valid_nxt;
    logic [31:0]          w_resp_rdata_nxt;
    logic                 w_resp_err_nxt;
    logic                 w_unused;

    assign w_lsu_load_lvl  = lsu_isWaiting & lsu_ren;
    assign w_lsu_store_lvl = lsu_isWaiting & lsu_wen;

    // Edge-type events compare against a delayed copy that resets to 0,
    // so a level already high when reset releases counts once.
    assign w_event[EV_CYCLE]        = 1'b1;
    assign w_event[EV_INST]         = ifu_valid;
    assign w_event[EV_ICACHE_FETCH] = icache_start & ~r_icache_start_d;
    assign w_event[EV_ICACHE_HIT]   = icache_valid & icache_isHit;
    assign w_event[EV_ICACHE_MISS]  = icache_valid & ~icache_isHit;
    assign w_event[EV_LSU_LOAD]     = w_lsu_load_lvl & ~r_lsu_load_d;
    assign w_event[EV_LSU_STORE]    = w_lsu_store_lvl & ~r_lsu_store_d;
    assign w_event[EV_LSU_WAIT]     = lsu_isWaiting;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        perf_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .i_clk    (clk),
            .i_rst_n  (reset),
            .i_inc    (w_event[gi]),
            .i_clear  (w_clear),
            .i_freeze (r_freeze),
            .o_count  (w_count[gi])
        );
    end

    assign w_accept  = (r_state == ST_IDLE) & req_valid;
    assign w_is_cnt  = (req_addr[7:6] == 2'b00);
    assign w_is_ctrl = (req_addr[7:2] == CTRL_ADDR[7:2]);
    assign w_idx     = req_addr[5:3];
    assign w_sel     = w_count[w_idx];
    assign w_sel_hi  = 32'(w_sel[CNT_WIDTH-1:32]);
    assign w_unused  = ^{req_addr[1:0], req_wdata[31:2]};

    // address decode and side effects of an accepted request
    always_comb begin
        w_rdata       = 32'h0;
        w_err         = 1'b0;
        w_shadow_load = 1'b0;
        w_clear       = 1'b0;
        w_freeze_nxt  = r_freeze;
        if (w_accept) begin
            if (w_is_cnt) begin
                if (req_wen) begin
                    w_err = 1'b1;
                end else if (req_addr[2]) begin
                    w_rdata = r_shadow;
                end else begin
                    w_rdata       = w_sel[31:0];
                    w_shadow_load = 1'b1;
                end
            end else if (w_is_ctrl) begin
                if (req_wen) begin
                    w_freeze_nxt = req_wdata[CTRL_FREEZE_BIT];
                    w_clear      = req_wdata[CTRL_CLEAR_BIT];
                end else begin
                    w_rdata = {31'h0, r_freeze};
                end
            end else begin
                w_err = 1'b1;
            end
        end else begin
            w_freeze_nxt = r_freeze;
        end
    end

    // bus FSM next state and registered response outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready_nxt  = r_req_ready;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt      = ST_RESP;
                    w_req_ready_nxt  = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = w_rdata;
                    w_resp_err_nxt   = w_err;
                end else begin
                    w_req_ready_nxt  = 1'b1;
                    w_resp_valid_nxt = 1'b0;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_req_ready_nxt  = 1'b1;
                    w_resp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt      = ST_RESP;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_req_ready_nxt  = 1'b1;
                w_resp_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM, response, control, shadow and edge-history registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'h0;
            r_resp_err       <= 1'b0;
            r_freeze         <= 1'b0;
            r_shadow         <= 32'h0;
            r_icache_start_d <= 1'b0;
            r_lsu_load_d     <= 1'b0;
            r_lsu_store_d    <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_req_ready      <= w_req_ready_nxt;
            r_resp_valid     <= w_resp_valid_nxt;
            r_resp_rdata     <= w_resp_rdata_nxt;
            r_resp_err       <= w_resp_err_nxt;
            r_freeze         <= w_freeze_nxt;
            r_icache_start_d <= icache_start;
            r_lsu_load_d     <= w_lsu_load_lvl;
            r_lsu_store_d    <= w_lsu_store_lvl;
            if (w_clear) begin
                r_shadow <= 32'h0;
            end else if (w_shadow_load) begin
                r_shadow <= w_sel_hi;
            end else begin
                r_shadow <= r_shadow;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: a cycle model predicts each response
// when the request is accepted; responses are popped and compared as they appear.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_valid = 1'b0, icache_valid = 1'b0, icache_start = 1'b0, icache_isHit = 1'b0;
    logic        lsu_ren = 1'b0, lsu_wen = 1'b0, lsu_isWaiting = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
    logic [7:0]  req_addr = 8'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [32:0] sb_q[$];

    logic [63:0] m_cnt [8];
    logic [31:0] m_shadow;
    logic        m_freeze, m_busy, m_prev_start, m_prev_load, m_prev_store;

    perf_counter_bank #(.CNT_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .ifu_valid(ifu_valid), .icache_valid(icache_valid), .icache_start(icache_start),
        .icache_isHit(icache_isHit), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_isWaiting(lsu_isWaiting), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 64'h0;
        m_shadow = 32'h0; m_freeze = 1'b0; m_busy = 1'b0;
        m_prev_start = 1'b0; m_prev_load = 1'b0; m_prev_store = 1'b0;
        sb_q.delete();
    endtask

    task automatic m_step();
        logic [7:0] ev;
        logic       clr;
        logic       nfrz;
        ev[0] = 1'b1;
        ev[1] = ifu_valid;
        ev[2] = icache_start && !m_prev_start;
        ev[3] = icache_valid && icache_isHit;
        ev[4] = icache_valid && !icache_isHit;
        ev[5] = lsu_isWaiting && lsu_ren && !m_prev_load;
        ev[6] = lsu_isWaiting && lsu_wen && !m_prev_store;
        ev[7] = lsu_isWaiting;
        clr = 1'b0;
        nfrz = m_freeze;
        if (m_busy) begin
            if (resp_ready) m_busy = 1'b0;
        end else if (req_valid) begin
            m_busy = 1'b1;
            if (req_addr < 8'h40) begin
                if (req_wen) sb_q.push_back({1'b1, 32'h0});
                else if (req_addr[2]) sb_q.push_back({1'b0, m_shadow});
                else begin
                    sb_q.push_back({1'b0, m_cnt[req_addr[5:3]][31:0]});
                    m_shadow = m_cnt[req_addr[5:3]][63:32];
                end
            end else if (req_addr[7:2] == 6'h10) begin
                if (req_wen) begin
                    nfrz = req_wdata[0];
                    clr  = req_wdata[1];
                    sb_q.push_back({1'b0, 32'h0});
                end else sb_q.push_back({1'b0, 31'h0, m_freeze});
            end else sb_q.push_back({1'b1, 32'h0});
        end
        for (int i = 0; i < 8; i++) begin
            if (clr) m_cnt[i] = 64'h0;
            else if (!m_freeze && ev[i]) m_cnt[i] = m_cnt[i] + 64'd1;
        end
        if (clr) m_shadow = 32'h0;
        m_freeze     = nfrz;
        m_prev_start = icache_start;
        m_prev_load  = lsu_isWaiting && lsu_ren;
        m_prev_store = lsu_isWaiting && lsu_wen;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic wen, input logic [7:0] addr, input logic [31:0] wdata,
                          input string name, output logic [31:0] rd, output logic er);
        logic [32:0] exp;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        cyc();
        req_valid = 1'b0; req_wen = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency: resp_valid=%b, required 1", name, resp_valid);
        end
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: no expected entry, got err=%b rdata=%h", name, resp_err, resp_rdata);
        end else begin
            exp = sb_q.pop_front();
            if ({resp_err, resp_rdata} !== exp)
                begin n_fail++; $display("FAIL %s: got err=%b rdata=%h, required err=%b rdata=%h",
                    name, resp_err, resp_rdata, exp[32], exp[31:0]); end
        end
        rd = resp_rdata; er = resp_err;
        cyc();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_idle();
        logic [31:0] rd; logic er;
        repeat (100) cyc();
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 8'(8 * i), 32'h0, "idle_lo", rd, er);
            n_cmp++;
            if ((i == 0) ? (rd < 32'd100 || rd > 32'd110) : (rd !== 32'h0)) begin
                n_fail++; $display("FAIL idle_lo_c%0d: got %0d", i, rd);
            end
            do_req(1'b0, 8'(8 * i + 4), 32'h0, "idle_hi", rd, er);
            n_cmp++;
            if (rd !== 32'h0) begin n_fail++; $display("FAIL idle_hi_c%0d: got %h, required 0", i, rd); end
        end
    endtask

    task automatic check_lo(input int idx, input logic [31:0] want, input string name);
        logic [31:0] rd; logic er;
        do_req(1'b0, 8'(8 * idx), 32'h0, name, rd, er);
        n_cmp++;
        if (rd !== want) begin n_fail++; $display("FAIL %s_const: got %0d, required %0d", name, rd, want); end
    endtask

    task automatic test_events();
        repeat (5) begin ifu_valid = 1'b1; cyc(); ifu_valid = 1'b0; cyc(); end
        for (int k = 0; k < 5; k++) begin
            icache_valid = 1'b1; icache_isHit = (k < 3); cyc();
            icache_valid = 1'b0; icache_isHit = 1'b0; cyc();
        end
        icache_start = 1'b1; repeat (3) cyc(); icache_start = 1'b0; repeat (2) cyc();
        icache_start = 1'b1; repeat (2) cyc(); icache_start = 1'b0; cyc();
        check_lo(1, 32'd5, "c1_inst");
        check_lo(2, 32'd2, "c2_fetch");
        check_lo(3, 32'd3, "c3_hit");
        check_lo(4, 32'd2, "c4_miss");
    endtask

    task automatic test_lsu();
        lsu_isWaiting = 1'b1; lsu_ren = 1'b1; repeat (4) cyc();
        lsu_isWaiting = 1'b0; lsu_ren = 1'b0; cyc();
        lsu_isWaiting = 1'b1; lsu_wen = 1'b1; repeat (2) cyc();
        lsu_isWaiting = 1'b0; lsu_wen = 1'b0; cyc();
        check_lo(5, 32'd1, "c5_load");
        check_lo(6, 32'd1, "c6_store");
        check_lo(7, 32'd6, "c7_wait");
    endtask

    task automatic test_freeze_clear();
        logic [31:0] rd; logic er;
        do_req(1'b1, 8'h40, 32'h1, "wr_freeze", rd, er);
        repeat (3) begin ifu_valid = 1'b1; cyc(); ifu_valid = 1'b0; cyc(); end
        icache_start = 1'b1; cyc(); icache_start = 1'b0; cyc();
        check_lo(1, 32'd5, "frozen_c1");
        check_lo(2, 32'd2, "frozen_c2");
        do_req(1'b0, 8'h40, 32'h0, "rd_ctrl1", rd, er);
        n_cmp++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL ctrl_freeze_rd: got %h, required 1", rd); end
        do_req(1'b1, 8'h40, 32'h2, "wr_clear", rd, er);
        check_lo(0, 32'd1, "c0_after_clear");
        check_lo(1, 32'd0, "c1_after_clear");
        do_req(1'b0, 8'h41, 32'h0, "rd_ctrl0", rd, er);
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL ctrl_clear_rd: got %h, required 0", rd); end
        do_req(1'b1, 8'h04, 32'hDEAD_BEEF, "wr_cnt_err", rd, er);
        n_cmp++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL wr_cnt_err: err=%b, required 1", er); end
        do_req(1'b0, 8'h44, 32'h0, "rd_bad_addr", rd, er);
        n_cmp++;
        if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bad_addr: err=%b rdata=%h, required 1 0", er, rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er;
        force dut.g_cnt[0].u_cnt.r_count = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc();
        release dut.g_cnt[0].u_cnt.r_count;
        m_cnt[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        check_lo(0, 32'hFFFF_FFFE, "wrap_lo_pre");
        do_req(1'b0, 8'h04, 32'h0, "wrap_hi_shadow", rd, er);
        n_cmp++;
        if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_shadow: got %h, required ffffffff", rd); end
        do_req(1'b0, 8'h00, 32'h0, "wrap_lo_post", rd, er);
        n_cmp++;
        if (rd > 32'd16) begin n_fail++; $display("FAIL wrap_lo_small: got %0d, required <= 16", rd); end
        do_req(1'b0, 8'h04, 32'h0, "wrap_hi_post", rd, er);
        n_cmp++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_hi_zero: got %h, required 0", rd); end
    endtask

    task automatic test_back_to_back_hold_reset();
        logic [32:0] exp;
        logic [31:0] rd; logic er;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h00;
        cyc();
        req_valid = 1'b0;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h1_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL hold_c%0d: valid=%b ready=%b err=%b rdata=%h, required 1 0 %b %h",
                         k, resp_valid, req_ready, resp_err, resp_rdata, exp[32], exp[31:0]);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resp: resp_valid=%b, required 0", resp_valid); end
        resp_ready = 1'b1;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL after_reset: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
        cyc();
        check_lo(1, 32'd0, "c1_post_reset");
        do_req(1'b0, 8'h3C, 32'h0, "c7_hi_post_reset", rd, er);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_events();
        test_lsu();
        test_freeze_clear();
        test_wrap();
        test_back_to_back_hold_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
